// File: rtl/uart_rgb_parser.sv
// Parses HEADER,R,G,B,CHK byte frames into registered RGB outputs with one-cycle result pulses.
// Latency: pulse one cycle after the CHK byte or timeout expiry; no backpressure, every rx_valid byte is consumed.
module uart_rgb_parser #(
    parameter logic [7:0]  HEADER         = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] rgb_red,
    output logic [7:0] rgb_green,
    output logic [7:0] rgb_blue,
    output logic       rgb_update,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        GET_R,
        GET_G,
        GET_B,
        GET_CHK
    } state_t;

    localparam logic [23:0] TO_LAST = 24'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [7:0]  shd_r_q, shd_g_q, shd_b_q;
    logic [7:0]  red_q, green_q, blue_q;
    logic        update_q, err_q;
    logic [7:0]  chk_d;

    // Carries past bit 7 fall off by truncation to 8 bits.
    assign chk_d = shd_r_q + shd_g_q + shd_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shd_r_q  <= '0;
            shd_g_q  <= '0;
            shd_b_q  <= '0;
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            update_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            err_q    <= 1'b0;
            if (rx_valid) begin
                // A byte arriving on the expiry cycle wins over the timeout.
                cnt_q <= '0;
                case (state_q)
                    IDLE: begin
                        if (rx_data == HEADER) begin
                            state_q <= GET_R;
                        end
                    end
                    GET_R: begin
                        shd_r_q <= rx_data;
                        state_q <= GET_G;
                    end
                    GET_G: begin
                        shd_g_q <= rx_data;
                        state_q <= GET_B;
                    end
                    GET_B: begin
                        shd_b_q <= rx_data;
                        state_q <= GET_CHK;
                    end
                    GET_CHK: begin
                        if (rx_data == chk_d) begin
                            red_q    <= shd_r_q;
                            green_q  <= shd_g_q;
                            blue_q   <= shd_b_q;
                            update_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end else if (state_q != IDLE) begin
                if (cnt_q == TO_LAST) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    shd_r_q <= '0;
                    shd_g_q <= '0;
                    shd_b_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 24'd1;
                end
            end
        end
    end

    assign rgb_red    = red_q;
    assign rgb_green  = green_q;
    assign rgb_blue   = blue_q;
    assign rgb_update = update_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rgb_parser.sv
// Scoreboard bench for uart_rgb_parser: expected pulses are queued with their cycle when the
// triggering byte is driven, and matched against DUT pulses observed on the falling edge.
module tb_uart_rgb_parser;

    localparam int unsigned TO = 40;
    localparam logic [7:0]  HDR = 8'hA5;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic [7:0] rgb_red, rgb_green, rgb_blue;
    logic       rgb_update, frame_err, busy;

    uart_rgb_parser #(
        .HEADER         (HDR),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rgb_red    (rgb_red),
        .rgb_green  (rgb_green),
        .rgb_blue   (rgb_blue),
        .rgb_update (rgb_update),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    typedef struct {
        int         cyc;
        bit         upd;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } exp_t;

    exp_t       sb[$];
    int         cyc;
    int         tests_run;
    int         tests_failed;
    int         last_cyc;
    logic [7:0] mr, mg, mb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input int at, input bit upd);
        exp_t e;
        e.cyc = at;
        e.upd = upd;
        e.r   = mr;
        e.g   = mg;
        e.b   = mb;
        sb.push_back(e);
    endtask

    // Pulses arrive at the falling edge after the sampling rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rgb_update && frame_err) check("both_pulses", 1, 0);
            if (rgb_update || frame_err) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {31'd0, rgb_update}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("pulse_cycle", cyc, e.cyc);
                    check("pulse_kind_update", {31'd0, rgb_update}, {31'd0, e.upd});
                    check("red", {24'd0, rgb_red}, {24'd0, e.r});
                    check("green", {24'd0, rgb_green}, {24'd0, e.g});
                    check("blue", {24'd0, rgb_blue}, {24'd0, e.b});
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                check("missing_pulse", sb[0].cyc, cyc);
                void'(sb.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        last_cyc = cyc;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // kind: 0 = no pulse expected, 1 = pulse judged from the checksum
    task automatic send_frame(input bit hdr, input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic [7:0] c, input int kind);
        logic [7:0] bytes [5];
        logic [7:0] sum;
        int         n;
        sum = r + g + b;
        n   = hdr ? 5 : 4;
        if (hdr) begin
            bytes[0] = HDR; bytes[1] = r; bytes[2] = g; bytes[3] = b; bytes[4] = c;
        end else begin
            bytes[0] = r; bytes[1] = g; bytes[2] = b; bytes[3] = c; bytes[4] = 8'h00;
        end
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = bytes[i];
            if (i == n - 1 && kind == 1) begin
                if (c == sum) begin
                    mr = r; mg = g; mb = b;
                    push_exp(cyc + 1, 1'b1);
                end else begin
                    push_exp(cyc + 1, 1'b0);
                end
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests_run = 0; tests_failed = 0; last_cyc = 0;
        mr = 8'h00; mg = 8'h00; mb = 8'h00;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_red", {24'd0, rgb_red}, 0);
        check("rst_green", {24'd0, rgb_green}, 0);
        check("rst_blue", {24'd0, rgb_blue}, 0);
        check("rst_update", {31'd0, rgb_update}, 0);
        check("rst_err", {31'd0, frame_err}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send_frame(1'b1, 8'h10, 8'h20, 8'h30, 8'h60, 1);
        check("busy_after_good", {31'd0, busy}, 0);
        send_frame(1'b1, 8'h10, 8'h20, 8'h30, 8'h61, 1);
        check("busy_after_bad", {31'd0, busy}, 0);
        send_frame(1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFD, 1);

        // Stray bytes in IDLE are ignored silently.
        send_byte(8'h00); check("idle_busy_00", {31'd0, busy}, 0);
        send_byte(8'hFF); check("idle_busy_ff", {31'd0, busy}, 0);
        send_byte(8'h3C); check("idle_busy_3c", {31'd0, busy}, 0);
        send_frame(1'b1, 8'hA5, 8'hA5, 8'hA5, 8'hEF, 1);

        // A failing CHK equal to HEADER must not open a new frame.
        send_frame(1'b1, 8'h01, 8'h01, 8'h01, 8'hA5, 1);
        send_frame(1'b0, 8'h02, 8'h03, 8'h04, 8'h09, 0);
        check("no_resync_busy", {31'd0, busy}, 0);

        // Timeout after a partial frame.
        send_byte(HDR);
        send_byte(8'h10);
        check("partial_busy", {31'd0, busy}, 1);
        push_exp(last_cyc + 1 + int'(TO), 1'b0);
        repeat (TO + 2) @(negedge clk);
        check("timeout_busy", {31'd0, busy}, 0);
        send_frame(1'b1, 8'h01, 8'h02, 8'h03, 8'h06, 1);

        // Byte on the expiry cycle wins.
        send_byte(HDR);
        repeat (TO - 2) @(negedge clk);
        send_frame(1'b0, 8'h11, 8'h22, 8'h33, 8'h66, 1);
        check("edge_busy", {31'd0, busy}, 0);

        // One cycle later the timeout fires first and the tail is ignored.
        send_byte(HDR);
        repeat (TO - 1) @(negedge clk);
        push_exp(last_cyc + 1 + int'(TO), 1'b0);
        send_frame(1'b0, 8'h44, 8'h55, 8'h66, 8'hFF, 0);
        check("late_busy", {31'd0, busy}, 0);

        // Reset mid-frame.
        send_byte(HDR);
        send_byte(8'h10);
        send_byte(8'h20);
        check("mid_busy", {31'd0, busy}, 1);
        rst_n = 1'b0;
        #1;
        mr = 8'h00; mg = 8'h00; mb = 8'h00;
        check("mid_rst_red", {24'd0, rgb_red}, 0);
        check("mid_rst_green", {24'd0, rgb_green}, 0);
        check("mid_rst_blue", {24'd0, rgb_blue}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_pulses", {30'd0, rgb_update, frame_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_frame(1'b1, 8'h07, 8'h08, 8'h09, 8'h18, 1);

        // Outputs must hold with no activity.
        repeat (TO + 5) @(negedge clk);
        check("hold_red", {24'd0, rgb_red}, {24'd0, mr});
        check("hold_green", {24'd0, rgb_green}, {24'd0, mg});
        check("hold_blue", {24'd0, rgb_blue}, {24'd0, mb});
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
